// File: rtl/skinny_ctrl_pkg.sv
// Shared types and constants for the Skinny-64 masked S-box layer controller.
// The nibble-select helper is used by the top-level issue mux.
package skinny_ctrl_pkg;

    localparam int NIBBLES = 16;
    localparam int SHARE_W = 64;
    localparam int NIB_W   = 4;
    localparam int RND_W   = 8;
    localparam int CNT_W   = 5;
    localparam int IDX_W   = 4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } state_t;

    function automatic logic [NIB_W-1:0] get_nib(input logic [SHARE_W-1:0] s,
                                                 input logic [IDX_W-1:0]   idx);
        return s[{idx, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/sbox_valid_pipe.sv
// Delay line that follows each S-box call through the core pipeline, carrying a
// valid flag and the nibble index so returning outputs land in the right slot.
module sbox_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            idx_q[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// Runs the 16-nibble S-box layer of a 3-share Skinny-64 state through one shared
// masked S-box core, one nibble per cycle, and reassembles the shared result.
module skinny_sbox_layer_ctrl
    import skinny_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [SHARE_W-1:0] st1_i,
    input  logic [SHARE_W-1:0] st2_i,
    input  logic [SHARE_W-1:0] st3_i,
    output logic               in_ready_o,
    input  logic [RND_W-1:0]   rnd_i,
    input  logic               rnd_valid_i,
    output logic               rnd_ready_o,
    output logic [NIB_W-1:0]   sbox_in1_o,
    output logic [NIB_W-1:0]   sbox_in2_o,
    output logic [NIB_W-1:0]   sbox_in3_o,
    output logic [RND_W-1:0]   sbox_r_o,
    input  logic [NIB_W-1:0]   sbox_out1_i,
    input  logic [NIB_W-1:0]   sbox_out2_i,
    input  logic [NIB_W-1:0]   sbox_out3_i,
    output logic [SHARE_W-1:0] res1_o,
    output logic [SHARE_W-1:0] res2_o,
    output logic [SHARE_W-1:0] res3_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               busy_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, ret_cnt_q;
    logic [SHARE_W-1:0] sh1_q, sh2_q, sh3_q;
    logic [SHARE_W-1:0] res1_q, res2_q, res3_q;
    logic               start_acc, issue;
    logic               cap_valid;
    logic [IDX_W-1:0]   cap_idx;

    assign start_acc = start_i && (state_q == IDLE);
    assign issue     = (state_q == ISSUE) && rnd_valid_i;

    sbox_valid_pipe #(
        .DEPTH (SBOX_LAT),
        .IDX_W (IDX_W)
    ) u_valid_pipe (
        .clk       (clk),
        .rst_i     (rst_i),
        .in_valid  (issue),
        .in_idx    (issue_cnt_q[IDX_W-1:0]),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ISSUE;
            ISSUE:   if (issue && issue_cnt_q == LAST_CNT) state_d = DRAIN;
            DRAIN:   if (cap_valid && ret_cnt_q == LAST_CNT) state_d = HOLD;
            HOLD:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Idle core inputs are forced to zero so no stale share or random word is re-presented.
    always_comb begin
        sbox_in1_o = '0;
        sbox_in2_o = '0;
        sbox_in3_o = '0;
        sbox_r_o   = '0;
        if (issue) begin
            sbox_in1_o = get_nib(sh1_q, issue_cnt_q[IDX_W-1:0]);
            sbox_in2_o = get_nib(sh2_q, issue_cnt_q[IDX_W-1:0]);
            sbox_in3_o = get_nib(sh3_q, issue_cnt_q[IDX_W-1:0]);
            sbox_r_o   = rnd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            sh3_q       <= '0;
            res1_q      <= '0;
            res2_q      <= '0;
            res3_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                sh1_q       <= st1_i;
                sh2_q       <= st2_i;
                sh3_q       <= st3_i;
                issue_cnt_q <= '0;
                ret_cnt_q   <= '0;
            end
            if (issue) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (cap_valid) begin
                res1_q[{cap_idx, 2'b00} +: NIB_W] <= sbox_out1_i;
                res2_q[{cap_idx, 2'b00} +: NIB_W] <= sbox_out2_i;
                res3_q[{cap_idx, 2'b00} +: NIB_W] <= sbox_out3_i;
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == HOLD);
    assign rnd_ready_o = issue;
    assign res1_o      = res1_q;
    assign res2_o      = res2_q;
    assign res3_o      = res3_q;

endmodule
